// File: rtl/entity_pkg.sv
// Shared entity-slot definitions: word field layout, screen geometry and writer FSM states.
// Used by both the entity table writer and the frame buffer renderer.
package entity_pkg;

  localparam int NUM_SLOTS    = 9;
  localparam int V_VISIBLE    = 480;
  localparam int SCREENSIZE_H = 16;
  localparam int SCREENSIZE_V = 12;
  localparam int NUM_LOCS     = SCREENSIZE_H * SCREENSIZE_V;

  localparam int ID_MSB     = 13;
  localparam int ID_LSB     = 10;
  localparam int ORIENT_MSB = 9;
  localparam int ORIENT_LSB = 8;
  localparam int LOC_MSB    = 7;
  localparam int LOC_LSB    = 0;

  localparam int ID_W     = ID_MSB - ID_LSB + 1;
  localparam int ORIENT_W = ORIENT_MSB - ORIENT_LSB + 1;
  localparam int LOC_W    = LOC_MSB - LOC_LSB + 1;
  localparam int ENTITY_W = ID_W + ORIENT_W + LOC_W;

  typedef logic [ENTITY_W-1:0] entity_word_t;

  localparam logic [ID_W-1:0] ENTITY_UNUSED_ID  = 4'hF;
  localparam entity_word_t    ENTITY_RESET_WORD = {ENTITY_UNUSED_ID, {ORIENT_W{1'b0}}, {LOC_W{1'b0}}};

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } writer_state_e;

  // An unused entity may carry any location; a live one must sit on the tile grid.
  function automatic logic word_is_placeable(entity_word_t w);
    return (w[ID_MSB:ID_LSB] == ENTITY_UNUSED_ID) || (int'(w[LOC_MSB:LOC_LSB]) < NUM_LOCS);
  endfunction

endpackage

// File: rtl/raster_tick_gen.sv
// Produces a single registered frame_tick when the raster first reaches the start of vertical blank.
module raster_tick_gen
  import entity_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_V,
  input  logic [9:0] counter_H,
  output logic       frame_tick
);

  logic at_commit_point;
  logic at_commit_point_q;
  logic tick_q;

  assign at_commit_point = (counter_V == 10'(V_VISIBLE)) && (counter_H == 10'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      at_commit_point_q <= 1'b0;
      tick_q            <= 1'b0;
    end else begin
      at_commit_point_q <= at_commit_point;
      tick_q            <= at_commit_point && !at_commit_point_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/entity_table_writer.sv
// Double-buffered entity slot table: writes land in a shadow bank copied to the outputs at vertical blank.
// Define ENTITY_BOUNDS_CHECK_EN to drop off-grid or bad-slot writes and raise the sticky err output.
module entity_table_writer
  import entity_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_slot,
  input  logic [ENTITY_W-1:0] wr_data,
  input  logic                clr_req,
  input  logic [9:0]          counter_V,
  input  logic [9:0]          counter_H,
  output logic [ENTITY_W-1:0] entity_1,
  output logic [ENTITY_W-1:0] entity_2,
  output logic [ENTITY_W-1:0] entity_3,
  output logic [ENTITY_W-1:0] entity_4,
  output logic [ENTITY_W-1:0] entity_5,
  output logic [ENTITY_W-1:0] entity_6,
  output logic [ENTITY_W-1:0] entity_7,
  output logic [ENTITY_W-1:0] entity_8,
  output logic [ENTITY_W-1:0] entity_9,
  output logic                dirty,
  output logic                frame_committed
`ifdef ENTITY_BOUNDS_CHECK_EN
  ,
  output logic                err
`endif
);

  writer_state_e state_q, state_d;
  entity_word_t  shadow_q [NUM_SLOTS];
  entity_word_t  shadow_d [NUM_SLOTS];
  entity_word_t  active_q [NUM_SLOTS];
  logic [3:0]    sweep_q, sweep_d;
  logic          dirty_q, dirty_d;
  logic          committed_q;

  logic frame_tick;
  logic accept;
  logic slot_ok;
  logic store;
  logic commit;

  raster_tick_gen u_tick (
    .clk        (clk),
    .reset      (reset),
    .counter_V  (counter_V),
    .counter_H  (counter_H),
    .frame_tick (frame_tick)
  );

  // A clear request takes priority, so the same-cycle write is refused rather than silently lost.
  assign wr_ready = (state_q == S_RUN) && !clr_req;
  assign accept   = wr_valid && wr_ready;
  assign slot_ok  = wr_slot < 4'(NUM_SLOTS);
  assign commit   = frame_tick && (state_q == S_RUN) && dirty_q;

`ifdef ENTITY_BOUNDS_CHECK_EN
  assign store = accept && slot_ok && word_is_placeable(wr_data);
`else
  assign store = accept && slot_ok;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    dirty_d  = dirty_q;
    shadow_d = shadow_q;
    unique case (state_q)
      S_RUN: begin
        if (commit) dirty_d = 1'b0;
        if (clr_req) begin
          state_d = S_CLEAR;
          sweep_d = 4'd0;
        end else if (store) begin
          shadow_d[wr_slot] = wr_data;
          dirty_d           = 1'b1;
        end
      end
      S_CLEAR: begin
        shadow_d[sweep_q] = ENTITY_RESET_WORD;
        sweep_d           = sweep_q + 4'd1;
        if (sweep_q == 4'(NUM_SLOTS - 1)) begin
          dirty_d = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: the shadow and active banks are reset because the renderer relies on a known "unused" scene.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      sweep_q     <= 4'd0;
      dirty_q     <= 1'b0;
      committed_q <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= ENTITY_RESET_WORD;
        active_q[k] <= ENTITY_RESET_WORD;
      end
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      dirty_q     <= dirty_d;
      committed_q <= commit;
      shadow_q    <= shadow_d;
      if (commit) active_q <= shadow_q;
    end
  end

`ifdef ENTITY_BOUNDS_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept && !clr_req && !(slot_ok && word_is_placeable(wr_data))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign entity_1        = active_q[0];
  assign entity_2        = active_q[1];
  assign entity_3        = active_q[2];
  assign entity_4        = active_q[3];
  assign entity_5        = active_q[4];
  assign entity_6        = active_q[5];
  assign entity_7        = active_q[6];
  assign entity_8        = active_q[7];
  assign entity_9        = active_q[8];
  assign dirty           = dirty_q;
  assign frame_committed = committed_q;

endmodule
